// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: convolution window scan controller.
// Walks (x, y, ch) window coordinates with a programmable stride and tracks
// them through a fixed-latency datapath. pixel_rdy/frame_done mark the
// datapath output.
// Build option: define SCAN_STALL_EN to make the stall input effective.
// Without it, stall is accepted but ignored.
module conv_scan_ctrl #(
   parameter int X_BITS     = 5,
   parameter int Y_BITS     = 5,
   parameter int CH_BITS    = 3,
   parameter int PIPE_DEPTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [X_BITS-1:0]  x_max,
   input  logic [Y_BITS-1:0]  y_max,
   input  logic [CH_BITS-1:0] ch_last,
   input  logic [1:0]         stride,
   input  logic               stall,
   output logic [X_BITS-1:0]  x_coord,
   output logic [Y_BITS-1:0]  y_coord,
   output logic [CH_BITS-1:0] ch_coord,
   output logic               coord_valid,
   output logic               pixel_rdy,
   output logic               frame_done,
   output logic               busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_t;

   state_t               state_q;
   logic [X_BITS-1:0]    x_q, xmax_q, x_d;
   logic [Y_BITS-1:0]    y_q, ymax_q, y_d;
   logic [CH_BITS-1:0]   ch_q, chl_q, ch_d;
   logic [1:0]           stride_q;
   logic [X_BITS:0]      x_sum;
   logic [Y_BITS:0]      y_sum;
   logic                 x_wrap, y_wrap, last_coord;
   logic                 advance;
   logic                 stall_eff;
   logic [PIPE_DEPTH-1:0] vld_q, vld_d, last_q, last_d;

`ifdef SCAN_STALL_EN
   assign stall_eff = stall;
`else
   // Port kept for a uniform interface; a constant 0 removes all hold logic.
   logic unused_stall;
   assign unused_stall = stall;
   assign stall_eff    = 1'b0;
`endif

   // A coordinate is issued in every non-stalled SCAN cycle.
   assign advance = (state_q == ST_SCAN) && !stall_eff;

   // Next coordinate: x fastest, then y, then channel; sums carry one spare bit.
   always_comb begin
      x_sum      = {1'b0, x_q} + (X_BITS+1)'(stride_q);
      y_sum      = {1'b0, y_q} + (Y_BITS+1)'(stride_q);
      x_wrap     = x_sum > {1'b0, xmax_q};
      y_wrap     = y_sum > {1'b0, ymax_q};
      last_coord = x_wrap && y_wrap && (ch_q == chl_q);
      x_d        = x_wrap ? '0 : x_sum[X_BITS-1:0];
      y_d        = y_q;
      ch_d       = ch_q;
      if (x_wrap) begin
         y_d = y_wrap ? '0 : y_sum[Y_BITS-1:0];
         if (y_wrap) begin
            ch_d = ch_q + CH_BITS'(1);
         end
      end
      if (last_coord) begin
         x_d  = '0;
         y_d  = '0;
         ch_d = '0;
      end
   end

   // Scan FSM: accepts a config in IDLE, steps counters in SCAN, waits out the pipe in DRAIN.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         ch_q     <= '0;
         xmax_q   <= '0;
         ymax_q   <= '0;
         chl_q    <= '0;
         stride_q <= 2'd1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  xmax_q   <= x_max;
                  ymax_q   <= y_max;
                  chl_q    <= ch_last;
                  stride_q <= (stride == 2'd0) ? 2'd1 : stride;
                  x_q      <= '0;
                  y_q      <= '0;
                  ch_q     <= '0;
                  state_q  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (advance) begin
                  x_q  <= x_d;
                  y_q  <= y_d;
                  ch_q <= ch_d;
                  if (last_coord) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // A stalled output tag has not been consumed yet, so wait for it.
               if (frame_done && !stall_eff) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Stage inputs: stage 0 takes the issued coordinate, later stages the previous one.
   for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
         assign vld_d[gi]  = advance;
         assign last_d[gi] = advance && last_coord;
      end else begin : g_body
         assign vld_d[gi]  = vld_q[gi-1];
         assign last_d[gi] = last_q[gi-1];
      end
   end

   // Valid and last-tag shift registers advance together and freeze on stall.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_q  <= '0;
         last_q <= '0;
      end else if (!stall_eff) begin
         vld_q  <= vld_d;
         last_q <= last_d;
      end
   end

   assign x_coord     = x_q;
   assign y_coord     = y_q;
   assign ch_coord    = ch_q;
   assign coord_valid = advance;
   assign pixel_rdy   = vld_q[PIPE_DEPTH-1];
   assign frame_done  = last_q[PIPE_DEPTH-1];
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Directed bench for conv_scan_ctrl (PIPE_DEPTH=8). Cycle 0 of every scan is
// the cycle in which start is driven high. Outputs are sampled 4 time units
// after the rising edge.
module tb_conv_scan_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic [4:0] x_max = '0;
   logic [4:0] y_max = '0;
   logic [2:0] ch_last = '0;
   logic [1:0] stride = '0;
   logic [4:0] x_coord, y_coord;
   logic [2:0] ch_coord;
   logic       coord_valid, pixel_rdy, frame_done, busy;

   int errors = 0;
   int checks = 0;

   int coords[$];
   int first_cv, last_cv, n_rdy, first_rdy, last_rdy, n_done, done_cyc, first_busy, last_busy;

   always #5 clock = ~clock;

   conv_scan_ctrl #(
      .X_BITS(5), .Y_BITS(5), .CH_BITS(3), .PIPE_DEPTH(8)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .x_max(x_max), .y_max(y_max), .ch_last(ch_last), .stride(stride), .stall(stall),
      .x_coord(x_coord), .y_coord(y_coord), .ch_coord(ch_coord),
      .coord_valid(coord_valid), .pixel_rdy(pixel_rdy), .frame_done(frame_done), .busy(busy)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected packed {ch,y,x} for coordinate i of a scan pattern.
   // mode 0: 4 x 3 window, stride 1, one channel; mode 1: x,y in {0,2,4}, two channels.
   function automatic int exp_coord(input int mode, input int i);
      int x, y, ch;
      x = 0; y = 0; ch = 0;
      if (mode == 0) begin
         x = i % 4; y = i / 4;
      end else if (mode == 1) begin
         x = 2 * (i % 3); y = 2 * ((i / 3) % 3); ch = i / 9;
      end
      return (ch << 10) | (y << 5) | x;
   endfunction

   // Runs one scan for ncyc cycles. poke pulses start in SCAN (c=4) and DRAIN
   // (c=15) and changes x_max to 1 after acceptance; rst_at pulses reset.
   task automatic run_scan(input logic [4:0] xm, input logic [4:0] ym, input logic [2:0] chl,
                           input logic [1:0] st, input int stall_from, input int stall_len,
                           input bit poke, input int rst_at, input int ncyc);
      coords.delete();
      first_cv = -1; last_cv = -1; n_rdy = 0; first_rdy = -1; last_rdy = -1;
      n_done = 0; done_cyc = -1; first_busy = -1; last_busy = -1;
      for (int c = 0; c < ncyc; c++) begin
         start = (c == 0) || (poke && (c == 4 || c == 15));
         if (c == 0) begin
            x_max = xm; y_max = ym; ch_last = chl; stride = st;
         end else if (poke) begin
            x_max = 5'd1;
         end
         stall = (c >= stall_from) && (c < stall_from + stall_len);
         reset = !(c == rst_at);
         #3;
         if (c == rst_at) begin
            check_eq("rst coord_valid", int'(coord_valid), 0);
            check_eq("rst pixel_rdy", int'(pixel_rdy), 0);
            check_eq("rst frame_done", int'(frame_done), 0);
            check_eq("rst busy", int'(busy), 0);
            check_eq("rst x_coord", int'(x_coord), 0);
         end
         if (coord_valid) begin
            coords.push_back((int'(ch_coord) << 10) | (int'(y_coord) << 5) | int'(x_coord));
            if (first_cv < 0) first_cv = c;
            last_cv = c;
         end
         if (pixel_rdy) begin
            n_rdy++;
            if (first_rdy < 0) first_rdy = c;
            last_rdy = c;
         end
         if (frame_done) begin
            n_done++;
            done_cyc = c;
         end
         if (busy) begin
            if (first_busy < 0) first_busy = c;
            last_busy = c;
         end
         @(posedge clock);
         #1;
      end
      start = 1'b0; stall = 1'b0; reset = 1'b1;
      $display("scan xm=%0d ym=%0d chl=%0d st=%0d: coords=%0d cv=%0d..%0d rdy=%0d done=%0d@%0d busy_last=%0d",
               xm, ym, chl, st, coords.size(), first_cv, last_cv, n_rdy, n_done, done_cyc, last_busy);
   endtask

   task automatic check_frame(input string name, input int mode, input int exp_n,
                              input int exp_last_cv, input int exp_first_rdy, input int exp_last_rdy,
                              input int exp_done, input int exp_busy_last);
      check_eq({name, " n_coord"}, coords.size(), exp_n);
      check_eq({name, " first_cv"}, first_cv, 1);
      check_eq({name, " last_cv"}, last_cv, exp_last_cv);
      check_eq({name, " n_rdy"}, n_rdy, exp_n);
      check_eq({name, " first_rdy"}, first_rdy, exp_first_rdy);
      check_eq({name, " last_rdy"}, last_rdy, exp_last_rdy);
      check_eq({name, " n_done"}, n_done, 1);
      check_eq({name, " done_cyc"}, done_cyc, exp_done);
      check_eq({name, " first_busy"}, first_busy, 0);
      check_eq({name, " last_busy"}, last_busy, exp_busy_last);
      for (int i = 0; i < coords.size() && i < exp_n; i++) begin
         check_eq($sformatf("%s coord%0d", name, i), coords[i], exp_coord(mode, i));
      end
   endtask

   initial begin
      // Reset state.
      #2 reset = 1'b0;
      #1;
      check_eq("reset coord_valid", int'(coord_valid), 0);
      check_eq("reset pixel_rdy", int'(pixel_rdy), 0);
      check_eq("reset frame_done", int'(frame_done), 0);
      check_eq("reset busy", int'(busy), 0);
      check_eq("reset coords", (int'(ch_coord) << 10) | (int'(y_coord) << 5) | int'(x_coord), 0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) begin @(posedge clock); #1; end

      // Basic 4x3x1 scan: start is sampled in cycle 0 but busy follows the state
      // register, so busy rises in cycle 1.
      run_scan(5'd3, 5'd2, 3'd0, 2'd1, -1, 0, 1'b0, -1, 30);
      first_busy = first_busy - 1;
      check_frame("basic", 0, 12, 12, 9, 20, 20, 20);

      // Stride 2, two channels: 18 coordinates.
      run_scan(5'd4, 5'd4, 3'd1, 2'd2, -1, 0, 1'b0, -1, 35);
      first_busy = first_busy - 1;
      check_frame("stride", 1, 18, 18, 9, 26, 26, 26);

      // Stall high in cycles 6..8 (after the 5th coordinate).
      run_scan(5'd3, 5'd2, 3'd0, 2'd1, 6, 3, 1'b0, -1, 35);
      first_busy = first_busy - 1;
`ifdef SCAN_STALL_EN
      check_frame("stall", 0, 12, 15, 12, 23, 23, 23);
`else
      check_frame("stall_ignored", 0, 12, 12, 9, 20, 20, 20);
`endif

      // start pulsed in SCAN and DRAIN, x_max changed after acceptance.
      run_scan(5'd3, 5'd2, 3'd0, 2'd1, -1, 0, 1'b1, -1, 35);
      first_busy = first_busy - 1;
      check_frame("poke", 0, 12, 12, 9, 20, 20, 20);
      x_max = 5'd3;

      // Reset at the 6th coordinate: nothing may emerge afterwards.
      run_scan(5'd3, 5'd2, 3'd0, 2'd1, -1, 0, 1'b0, 6, 30);
      check_eq("abort n_coord", coords.size(), 5);
      check_eq("abort n_rdy", n_rdy, 0);
      check_eq("abort n_done", n_done, 0);
      check_eq("abort last_busy", last_busy, 5);

      // Full scan after the aborted one.
      run_scan(5'd3, 5'd2, 3'd0, 2'd1, -1, 0, 1'b0, -1, 30);
      first_busy = first_busy - 1;
      check_frame("restart", 0, 12, 12, 9, 20, 20, 20);

      // Degenerate 1x1x1 with stride 0 (treated as 1).
      run_scan(5'd0, 5'd0, 3'd0, 2'd0, -1, 0, 1'b0, -1, 20);
      first_busy = first_busy - 1;
      check_frame("single", 2, 1, 1, 9, 9, 9, 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
